parking_input_conditioner: RTL and testbench
============================================

# parking_input_conditioner

Front-end conditioning stage that feeds the parking-gate controller FSM. It synchronises and debounces the raw entrance and exit presence sensors, and assembles a two-digit, 2-bit-per-digit password from a synchronous keypad strobe interface. It presents stable `sensor_entrance`, `sensor_exit`, `password_1` and `password_2` levels to the gate controller, which samples them every cycle.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronised sensor level must differ from the output before the output follows it (≥2).
- `ENTRY_TIMEOUT`, default 16: cycles allowed between first and second digit before the partial entry is discarded (≥2).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `raw_entrance` in 1: asynchronous entrance sensor, active-high.
- `raw_exit` in 1: asynchronous exit sensor, active-high.
- `key_valid` in 1: single-cycle digit strobe, synchronous to `clk`.
- `key_digit` in 2: digit value, valid when `key_valid`=1.
- `key_clear` in 1: synchronous clear request, level-sampled.
- `sensor_entrance` out 1: debounced entrance level.
- `sensor_exit` out 1: debounced exit level.
- `password_1` out 2: first captured digit.
- `password_2` out 2: second captured digit.
- `pass_ready` out 1: high while both digits are held.

## Operation
- Reset values: `sensor_entrance`=0, `sensor_exit`=0, `password_1`=2'b00, `password_2`=2'b00, `pass_ready`=0. Entry FSM is EMPTY, all counters are 0. 2'b00/2'b00 never matches the valid code 01/10.
- Sensor path, per sensor:
  - 2-flop synchroniser produces `s`.
  - Counter `cnt` is 0 while `s`==out.
  - While `s`!=out, `cnt` increments each cycle.
  - When `cnt`==DEBOUNCE_CYCLES-1 and `s` still differs, out<=`s` and `cnt`<=0.
  - Any return of `s` to out before that point resets `cnt`, so the pulse is rejected.
- Entry FSM states: EMPTY, ONE_DIGIT, COMPLETE.
  - EMPTY + `key_valid`: `password_1`<=`key_digit`, go to ONE_DIGIT.
  - ONE_DIGIT + `key_valid`: `password_2`<=`key_digit`, `pass_ready`<=1, go to COMPLETE.
  - ONE_DIGIT, no key: timeout counter increments. At ENTRY_TIMEOUT-1 with no key, clear both digits and go to EMPTY.
  - COMPLETE + `key_valid`: start a new entry. `password_1`<=`key_digit`, `password_2`<=00, `pass_ready`<=0, go to ONE_DIGIT.
  - COMPLETE holds indefinitely otherwise. It has no timeout.
- Clear event is `key_clear`=1, or the cycle in which debounced `sensor_exit` has just risen (registered edge detect). On the next edge: digits<=00, `pass_ready`<=0, FSM<=EMPTY, timeout counter<=0.
- Priority: clear event > timeout > `key_valid`. A `key_valid` coincident with a clear event is dropped.
- The timeout counter is 0 in every state except ONE_DIGIT. It resets on each digit capture.
- Reset asserted mid-entry or mid-debounce immediately returns all outputs and state to their reset values.

## Timing
- Sensor latency: a raw level stable from before edge 0 appears on the output after edge 1+DEBOUNCE_CYCLES, i.e. the 6th edge at default. A pulse shorter than DEBOUNCE_CYCLES cycles at `s` never reaches the output.
- Digit latency: a password register updates on the edge that samples `key_valid`. `pass_ready` rises on the same edge as `password_2`.
- Exit-triggered clear: digits read 00 one edge after `sensor_exit` rises. The gate controller therefore sees the correct code for at least the cycle in which `sensor_exit` first reads 1.
- Timeout: ENTRY_TIMEOUT edges after the first-digit capture edge with no `key_valid`, digits read 00.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `parking_pkg`:
  - entry-state enum (EMPTY, ONE_DIGIT, COMPLETE);
  - `DIGIT_W`=2;
  - `PASS_RESET`=2'b00;
  - valid-code constants `CODE_1`=2'b01 and `CODE_2`=2'b10, shared with the gate controller.
- Sub-module `sensor_debounce` (synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES), instantiated twice. Its counter width is $clog2(DEBOUNCE_CYCLES).
- Timeout counter width is $clog2(ENTRY_TIMEOUT).

## Test plan
- Reset, then drive `raw_entrance`=1 continuously: `sensor_entrance`=0 through edge 5, and 1 after edge 6. A 3-cycle `raw_exit` pulse: `sensor_exit` stays 0.
- Keys 01 then 10, 5 cycles apart: `password_1`=01 after the first strobe. `password_2`=10 and `pass_ready`=1 after the second.
- Key 01, then no key for 16 cycles: digits 00, `pass_ready`=0, FSM EMPTY. A key 10 arriving on cycle 15 instead completes the entry.
- COMPLETE holding 01/10, then raise `raw_exit`: `sensor_exit`=1 for one edge while the code still reads 01/10. Next edge: digits 00, `pass_ready`=0.
- `key_valid` (digit 11) coincident with `key_clear` in ONE_DIGIT: digits 00, EMPTY, digit dropped.
- Assert `rst_n`=0 mid-debounce and mid-entry, asynchronous to `clk`: all outputs 0 immediately. Counters restart after release.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-gate front end and controller.
package parking_pkg;

    localparam int unsigned DIGIT_W = 2;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        ONE_DIGIT = 2'd1,
        COMPLETE  = 2'd2
    } entry_state_t;

    localparam logic [DIGIT_W-1:0] PASS_RESET = 2'b00;
    localparam logic [DIGIT_W-1:0] CODE_1     = 2'b01;
    localparam logic [DIGIT_W-1:0] CODE_2     = 2'b10;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer for one presence sensor.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             s;

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Output only follows s after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            level <= 1'b0;
        end else if (s == level) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q <= '0;
            level <= s;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parking_input_conditioner.sv
// Debounces the entrance/exit sensors and assembles the two-digit keypad password
// presented to the parking-gate controller.
module parking_input_conditioner
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned ENTRY_TIMEOUT   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               raw_entrance,
    input  logic               raw_exit,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               key_clear,
    output logic               sensor_entrance,
    output logic               sensor_exit,
    output logic [DIGIT_W-1:0] password_1,
    output logic [DIGIT_W-1:0] password_2,
    output logic               pass_ready
);

    localparam int unsigned TMO_W = $clog2(ENTRY_TIMEOUT);

    entry_state_t       state_q, state_d;
    logic [DIGIT_W-1:0] pw1_q, pw1_d;
    logic [DIGIT_W-1:0] pw2_q, pw2_d;
    logic               ready_q, ready_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               exit_q;
    logic               clear_c;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entrance (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_entrance),
        .level (sensor_entrance)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_exit),
        .level (sensor_exit)
    );

    // A car leaving discards any held code, one edge after the exit level rises.
    assign clear_c = key_clear | (sensor_exit & ~exit_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            pw1_q   <= PASS_RESET;
            pw2_q   <= PASS_RESET;
            ready_q <= 1'b0;
            tmo_q   <= '0;
            exit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pw1_q   <= pw1_d;
            pw2_q   <= pw2_d;
            ready_q <= ready_d;
            tmo_q   <= tmo_d;
            exit_q  <= sensor_exit;
        end
    end

    always_comb begin
        state_d = state_q;
        pw1_d   = pw1_q;
        pw2_d   = pw2_q;
        ready_d = ready_q;
        tmo_d   = '0;
        if (clear_c) begin
            state_d = EMPTY;
            pw1_d   = PASS_RESET;
            pw2_d   = PASS_RESET;
            ready_d = 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (key_valid) begin
                        pw1_d   = key_digit;
                        state_d = ONE_DIGIT;
                    end
                end
                ONE_DIGIT: begin
                    if (key_valid) begin
                        pw2_d   = key_digit;
                        ready_d = 1'b1;
                        state_d = COMPLETE;
                    end else if (tmo_q == TMO_W'(ENTRY_TIMEOUT - 1)) begin
                        pw1_d   = PASS_RESET;
                        pw2_d   = PASS_RESET;
                        state_d = EMPTY;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                COMPLETE: begin
                    if (key_valid) begin
                        pw1_d   = key_digit;
                        pw2_d   = PASS_RESET;
                        ready_d = 1'b0;
                        state_d = ONE_DIGIT;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    pw1_d   = PASS_RESET;
                    pw2_d   = PASS_RESET;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    assign password_1 = pw1_q;
    assign password_2 = pw2_q;
    assign pass_ready = ready_q;

endmodule

// File: tb/tb_parking_input_conditioner.sv
// Bench for parking_input_conditioner: rule-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_parking_input_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       raw_entrance = 1'b0;
    logic       raw_exit = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_digit = 2'b00;
    logic       key_clear = 1'b0;
    logic       sensor_entrance, sensor_exit, pass_ready;
    logic [1:0] password_1, password_2;

    int total = 0;
    int bad   = 0;

    parking_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .ENTRY_TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .raw_entrance    (raw_entrance),
        .raw_exit        (raw_exit),
        .key_valid       (key_valid),
        .key_digit       (key_digit),
        .key_clear       (key_clear),
        .sensor_entrance (sensor_entrance),
        .sensor_exit     (sensor_exit),
        .password_1      (password_1),
        .password_2      (password_2),
        .pass_ready      (pass_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: sensors as "D consecutive differing samples of the
    // 2-edge-delayed raw level", entry as a queue of captured digits with an age.
    logic       m_sy1 [2];
    logic       m_s   [2];
    logic       m_out [2];
    int         m_run [2];
    logic       m_exit_prev;
    logic [1:0] m_dq [$];
    int         m_age;

    function automatic logic [1:0] m_pw1();
        return (m_dq.size() >= 1) ? m_dq[0] : 2'b00;
    endfunction
    function automatic logic [1:0] m_pw2();
        return (m_dq.size() == 2) ? m_dq[1] : 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sy1[i] = 1'b0; m_s[i] = 1'b0; m_out[i] = 1'b0; m_run[i] = 0;
        end
        m_exit_prev = 1'b0;
        m_dq.delete();
        m_age = 0;
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic clr;
            logic raw_v [2];
            raw_v[0] = raw_entrance;
            raw_v[1] = raw_exit;
            clr = key_clear || (m_out[1] && !m_exit_prev);
            if (clr) begin
                m_dq.delete();
                m_age = 0;
            end else if (m_dq.size() == 0) begin
                if (key_valid) begin m_dq.push_back(key_digit); m_age = 0; end
            end else if (m_dq.size() == 1) begin
                if (key_valid) begin
                    m_dq.push_back(key_digit);
                end else begin
                    m_age++;
                    if (m_age == TMO) begin m_dq.delete(); m_age = 0; end
                end
            end else if (key_valid) begin
                m_dq.delete();
                m_dq.push_back(key_digit);
                m_age = 0;
            end
            m_exit_prev = m_out[1];
            for (int i = 0; i < 2; i++) begin
                if (m_s[i] != m_out[i]) m_run[i]++; else m_run[i] = 0;
                if (m_run[i] == DEB) begin m_out[i] = m_s[i]; m_run[i] = 0; end
                m_s[i]   = m_sy1[i];
                m_sy1[i] = raw_v[i];
            end
        end
    end

    always @(negedge clk) begin
        chk("model_entrance", {1'b0, sensor_entrance}, {1'b0, m_out[0]});
        chk("model_exit",     {1'b0, sensor_exit},     {1'b0, m_out[1]});
        chk("model_pw1",      password_1, m_pw1());
        chk("model_pw2",      password_2, m_pw2());
        chk("model_ready",    {1'b0, pass_ready}, {1'b0, m_dq.size() == 2});
    end

    task automatic press(input logic [1:0] d);
        key_valid = 1'b1;
        key_digit = d;
        @(negedge clk);
        key_valid = 1'b0;
        key_digit = 2'b00;
    endtask

    task automatic chk_code(input string name, input logic [1:0] p1, input logic [1:0] p2,
                            input logic rdy);
        chk({name, "_pw1"}, password_1, p1);
        chk({name, "_pw2"}, password_2, p2);
        chk({name, "_ready"}, {1'b0, pass_ready}, {1'b0, rdy});
    endtask

    task automatic chk_all_zero(input string name);
        chk_code(name, 2'b00, 2'b00, 1'b0);
        chk({name, "_ent"}, {1'b0, sensor_entrance}, 2'b00);
        chk({name, "_exit"}, {1'b0, sensor_exit}, 2'b00);
    endtask

    initial begin
        bit seen;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");

        // Entrance latency: output rises on the 6th edge after release.
        rst_n = 1'b1;
        raw_entrance = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("ent_lat_e%0d", i), {1'b0, sensor_entrance}, {1'b0, i >= 6});
        end

        // A 3-cycle exit glitch is rejected.
        raw_exit = 1'b1;
        repeat (3) @(negedge clk);
        raw_exit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("exit_glitch", {1'b0, sensor_exit}, 2'b00);
        end

        // Two digits, five cycles apart.
        press(2'b01);
        chk_code("first_key", 2'b01, 2'b00, 1'b0);
        repeat (4) @(negedge clk);
        press(2'b10);
        chk_code("second_key", 2'b01, 2'b10, 1'b1);
        repeat (3) @(negedge clk);
        chk_code("complete_hold", 2'b01, 2'b10, 1'b1);

        // Timeout after 16 idle edges.
        key_clear = 1'b1;
        @(negedge clk);
        key_clear = 1'b0;
        chk_code("key_clear", 2'b00, 2'b00, 1'b0);
        press(2'b01);
        repeat (15) @(negedge clk);
        chk_code("pre_timeout", 2'b01, 2'b00, 1'b0);
        @(negedge clk);
        chk_code("timeout", 2'b00, 2'b00, 1'b0);

        // Second digit on the 15th edge after capture still completes.
        press(2'b01);
        repeat (14) @(negedge clk);
        press(2'b10);
        chk_code("late_second", 2'b01, 2'b10, 1'b1);

        // Exit-triggered clear: code visible for the first cycle sensor_exit is 1.
        raw_exit = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (sensor_exit) seen = 1'b1;
        end
        chk("exit_rise_seen", {1'b0, seen}, 2'b01);
        chk_code("exit_first_cycle", 2'b01, 2'b10, 1'b1);
        @(negedge clk);
        chk_code("exit_cleared", 2'b00, 2'b00, 1'b0);
        raw_exit = 1'b0;
        repeat (8) @(negedge clk);
        chk("exit_fell", {1'b0, sensor_exit}, 2'b00);

        // key_valid coincident with key_clear in ONE_DIGIT is dropped.
        press(2'b01);
        key_valid = 1'b1;
        key_digit = 2'b11;
        key_clear = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_clear = 1'b0;
        chk_code("clear_beats_key", 2'b00, 2'b00, 1'b0);
        press(2'b10);
        chk_code("after_clear_empty", 2'b10, 2'b00, 1'b0);

        // Asynchronous reset mid-entry and mid-debounce.
        raw_exit = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        repeat (2) @(negedge clk);
        chk_all_zero("reset_hold");
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("restart_ent_e%0d", i), {1'b0, sensor_entrance}, {1'b0, i >= 6});
            chk($sformatf("restart_exit_e%0d", i), {1'b0, sensor_exit}, {1'b0, i >= 6});
        end
        raw_entrance = 1'b0;
        raw_exit = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
